// File: rtl/lpce_pkg.sv
// Shared constants and types for the LPCE receive dispatcher.
// Header layout: [7:4] mark, [3:2] reserved (must be zero), [1:0] channel.
package lpce_pkg;
  localparam int LPCE_DATA_W = 128;
  localparam int LPCE_PAY_W  = 120;
  localparam int LPCE_HDR_MSB = 127;
  localparam int LPCE_HDR_LSB = 120;
  localparam logic [3:0] LPCE_HDR_MARK = 4'hA;

  typedef struct packed {
    logic [3:0] mark;
    logic [1:0] rsvd;
    logic [1:0] ch;
  } lpce_hdr_t;

  typedef enum logic [1:0] {IDLE, SEND, DROP} lpce_state_e;

  function automatic logic lpce_hdr_ok(input lpce_hdr_t h, input int num_ch);
    return (h.mark == LPCE_HDR_MARK) && (h.rsvd == 2'b00) &&
           (int'({30'd0, h.ch}) < num_ch);
  endfunction
endpackage

// File: rtl/lpce_rx_dispatch_if.sv
// FIFO read port plus the shared-payload consumer channels.
// master = dispatcher side, slave = FIFO/consumer side.
interface lpce_rx_dispatch_if
  import lpce_pkg::*;
#(
  parameter int NUM_CH = 4
);
  logic [LPCE_DATA_W-1:0] READ_DATA;
  logic                   READ_EMPT;
  logic                   READ_EN;
  logic [LPCE_PAY_W-1:0]  CH_DATA;
  logic [NUM_CH-1:0]      CH_VALID;
  logic [NUM_CH-1:0]      CH_READY;

  modport master (
    input  READ_DATA, READ_EMPT, CH_READY,
    output READ_EN, CH_DATA, CH_VALID
  );
  modport slave (
    output READ_DATA, READ_EMPT, CH_READY,
    input  READ_EN, CH_DATA, CH_VALID
  );
endinterface

// File: rtl/lpce_sat_cnt.sv
// 16-bit event counter that sticks at all-ones; clear has priority over increment.
// Result visible one cycle after the increment; no backpressure.
module lpce_sat_cnt (
  input  logic        READ_CLK,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] cnt
);
  always_ff @(posedge READ_CLK) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != 16'hFFFF)) begin
      cnt <= cnt + 16'd1;
    end
  end
endmodule

// File: rtl/lpce_rx_dispatch.sv
// Pops frames from a show-ahead FIFO, validates the header and hands the payload to one channel.
// Pop at t -> CH_VALID at t+1; holds the frame until READY or TIMEOUT, no pops while busy.
module lpce_rx_dispatch
  import lpce_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                READ_CLK,
  input  logic                RSTi,
  input  logic                EN,
  lpce_rx_dispatch_if.master  bus,
  output logic [15:0]         FRAME_CNT,
  output logic [15:0]         DROP_CNT,
  output logic                BUSY
);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  lpce_state_e           state;
  lpce_hdr_t             hdr;
  logic [1:0]            ch_q;
  logic [TW-1:0]         wait_q;
  logic [LPCE_PAY_W-1:0] pay_q;
  logic [NUM_CH-1:0]     valid_vec;
  logic                  pop, hit, tmo;

  assign hdr = bus.READ_DATA[LPCE_HDR_MSB:LPCE_HDR_LSB];
  assign pop = (state == IDLE) && EN && !bus.READ_EMPT;

  always_comb begin
    valid_vec = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      valid_vec[i] = (state == SEND) && (ch_q == 2'(i));
    end
  end

  // A transfer in the same cycle as the timeout wins, so tmo excludes hit.
  assign hit = |(valid_vec & bus.CH_READY);
  assign tmo = (TIMEOUT != 0) && (state == SEND) && !hit && (wait_q == TW'(TIMEOUT));

  always_ff @(posedge READ_CLK) begin
    if (RSTi) begin
      state  <= IDLE;
      ch_q   <= '0;
      wait_q <= '0;
      pay_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            pay_q  <= bus.READ_DATA[LPCE_PAY_W-1:0];
            ch_q   <= hdr.ch;
            wait_q <= '0;
            state  <= lpce_hdr_ok(hdr, NUM_CH) ? SEND : DROP;
          end
        end
        SEND: begin
          if (hit || tmo) begin
            state <= IDLE;
          end else begin
            wait_q <= wait_q + TW'(1);
          end
        end
        DROP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.READ_EN  = pop;
  assign bus.CH_VALID = valid_vec;
  assign bus.CH_DATA  = pay_q;
  assign BUSY         = (state != IDLE);

  lpce_sat_cnt u_frame_cnt (
    .READ_CLK (READ_CLK),
    .clr      (RSTi),
    .inc      (hit),
    .cnt      (FRAME_CNT)
  );

  lpce_sat_cnt u_drop_cnt (
    .READ_CLK (READ_CLK),
    .clr      (RSTi),
    .inc      ((state == DROP) || tmo),
    .cnt      (DROP_CNT)
  );
endmodule

// File: tb/tb_lpce_rx_dispatch.sv
// Two dispatchers (4 ch / timeout 4, and 2 ch / timeout disabled) fed identical frames,
// checked every cycle against a frame-level model plus directed literal expectations.
module tb_lpce_rx_dispatch;
  import lpce_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en;
  logic [3:0] rdy;
  logic [15:0] fa, da, fb, db;
  logic        ba, bb;

  lpce_rx_dispatch_if #(.NUM_CH(4)) ia ();
  lpce_rx_dispatch_if #(.NUM_CH(2)) ib ();

  lpce_rx_dispatch #(.NUM_CH(4), .TIMEOUT(4)) dut_a (
    .READ_CLK(clk), .RSTi(rst), .EN(en), .bus(ia.master),
    .FRAME_CNT(fa), .DROP_CNT(da), .BUSY(ba));
  lpce_rx_dispatch #(.NUM_CH(2), .TIMEOUT(0)) dut_b (
    .READ_CLK(clk), .RSTi(rst), .EN(en), .bus(ib.master),
    .FRAME_CNT(fb), .DROP_CNT(db), .BUSY(bb));

  // Show-ahead FIFOs: one shared store, one read pointer per DUT.
  logic [127:0] mem [0:127];
  int wr = 0, a_rd = 0, b_rd = 0;
  assign ia.READ_DATA = mem[a_rd];
  assign ia.READ_EMPT = (a_rd == wr);
  assign ib.READ_DATA = mem[b_rd];
  assign ib.READ_EMPT = (b_rd == wr);
  assign ia.CH_READY  = rdy;
  assign ib.CH_READY  = rdy[1:0];

  int n_chk = 0, n_err = 0;
  logic pend [2];
  int pops [2];
  int vcyc [2];
  int cyc = 0;
  int pcyc [$];
  logic [3:0]   gq [$];
  logic [119:0] gd [$];
  logic preload_a = 1'b0;

  task automatic chk(input int k, input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL dut_%s %s: got %0h expected %0h at %0t", (k == 0) ? "a" : "b", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  initial begin
    pend[0] = 0; pend[1] = 0;
    forever begin
      @(posedge clk); #1;
      if (pend[0]) a_rd++;
      if (pend[1]) b_rd++;
    end
  end

  // Frame-level model: a held frame (channel, age) or a pending drop, plus two counters.
  initial begin : compare
    int nch [2];
    int tmo [2];
    logic m_busy [2];
    logic m_drop [2];
    int m_ch [2];
    int m_wait [2];
    logic [119:0] m_pay [2];
    logic [15:0] m_fr [2];
    logic [15:0] m_dr [2];
    logic preload_done;
    logic [3:0] v_act, v_exp, rdy_k;
    logic [127:0] head;
    logic [119:0] d_act;
    logic [15:0] f_act, c_act;
    logic [7:0] h;
    logic empt, rd_act, busy_act, rd_exp;
    nch[0] = 4; nch[1] = 2; tmo[0] = 4; tmo[1] = 0;
    preload_done = 1'b0;
    pops[0] = 0; pops[1] = 0; vcyc[0] = 0; vcyc[1] = 0;
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_drop[k] = 0; m_ch[k] = 0; m_wait[k] = 0;
      m_pay[k] = '0; m_fr[k] = '0; m_dr[k] = '0;
    end
    forever begin
      @(negedge clk); #2;
      cyc++;
      if (preload_a && !preload_done) begin
        m_dr[0] = 16'hFFFE;
        preload_done = 1'b1;
      end
      for (int k = 0; k < 2; k++) begin
        if (k == 0) begin
          v_act = ia.CH_VALID; rd_act = ia.READ_EN; d_act = ia.CH_DATA; f_act = fa; c_act = da;
          busy_act = ba; empt = ia.READ_EMPT; head = ia.READ_DATA; rdy_k = rdy;
        end else begin
          v_act = {2'b00, ib.CH_VALID}; rd_act = ib.READ_EN; d_act = ib.CH_DATA; f_act = fb; c_act = db;
          busy_act = bb; empt = ib.READ_EMPT; head = ib.READ_DATA; rdy_k = {2'b00, rdy[1:0]};
        end
        rd_exp = en && !empt && !m_busy[k] && !m_drop[k];
        v_exp  = m_busy[k] ? (4'b0001 << m_ch[k]) : 4'b0000;
        chk(k, "read_en", rd_act, rd_exp);
        chk(k, "ch_valid", v_act, v_exp);
        chk(k, "ch_data", d_act, m_pay[k]);
        chk(k, "frame_cnt", f_act, m_fr[k]);
        chk(k, "drop_cnt", c_act, m_dr[k]);
        chk(k, "busy", busy_act, m_busy[k] || m_drop[k]);

        pend[k] = rd_act;
        if (rd_act) begin
          pops[k]++;
          if (k == 0) pcyc.push_back(cyc);
        end
        if (v_act != 0) vcyc[k]++;
        if (k == 0 && (v_act & rdy_k) != 0) begin
          gq.push_back(v_act);
          gd.push_back(d_act);
        end

        if (rst) begin
          m_busy[k] = 0; m_drop[k] = 0; m_ch[k] = 0; m_wait[k] = 0;
          m_pay[k] = '0; m_fr[k] = '0; m_dr[k] = '0;
        end else if (m_drop[k]) begin
          m_dr[k] = sat(m_dr[k]);
          m_drop[k] = 0;
        end else if (m_busy[k]) begin
          if (rdy_k[m_ch[k]]) begin
            m_fr[k] = sat(m_fr[k]);
            m_busy[k] = 0;
          end else if (tmo[k] != 0 && m_wait[k] == tmo[k]) begin
            m_dr[k] = sat(m_dr[k]);
            m_busy[k] = 0;
          end else begin
            m_wait[k]++;
          end
        end else if (rd_exp) begin
          h = head[127:120];
          m_pay[k] = head[119:0];
          if ((h >> 4) == 8'd10 && ((h >> 2) & 8'd3) == 0 && int'(h & 8'd3) < nch[k]) begin
            m_busy[k] = 1; m_ch[k] = int'(h & 8'd3); m_wait[k] = 0;
          end else begin
            m_drop[k] = 1;
          end
        end
      end
    end
  end

  task automatic push(input logic [7:0] hdr, input logic [119:0] pay);
    mem[wr] = {hdr, pay};
    wr++;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic settle(input int budget);
    int i = 0;
    while (i < budget && (ba || bb || a_rd != wr || b_rd != wr)) begin
      @(negedge clk);
      i++;
    end
    chk(0, "settle_busy", ba, 1'b0);
    chk(1, "settle_busy", bb, 1'b0);
    chk(0, "settle_fifo", a_rd, wr);
    chk(1, "settle_fifo", b_rd, wr);
    @(negedge clk);
  endtask

  initial begin
    int p0, pb, v0, vb, g0;
    rst = 1'b1; en = 1'b0; rdy = 4'h0;
    for (int i = 0; i < 128; i++) mem[i] = '0;
    cycles(3);
    chk(0, "rst_valid", ia.CH_VALID, 4'h0);
    chk(0, "rst_data", ia.CH_DATA, 120'h0);
    chk(0, "rst_busy", ba, 1'b0);
    rst = 1'b0;
    cycles(1);

    // Single frame to channel 1
    rdy = 4'hF; en = 1'b1;
    p0 = pops[0]; v0 = vcyc[0]; g0 = gq.size();
    push(8'hA1, 120'h1234);
    settle(20);
    chk(0, "t1_pops", pops[0] - p0, 1);
    chk(0, "t1_valid_cycles", vcyc[0] - v0, 1);
    chk(0, "t1_grant", gq[g0], 4'b0010);
    chk(0, "t1_data", gd[g0], 120'h1234);
    chk(0, "t1_frames", fa, 16'd1);
    chk(1, "t1_frames", fb, 16'd1);

    // Back-to-back frames to channels 0, 3, 2
    p0 = pcyc.size(); g0 = gq.size();
    push(8'hA0, 120'h111); push(8'hA3, 120'h333); push(8'hA2, 120'h222);
    settle(30);
    chk(0, "t2_grant0", gq[g0], 4'b0001);
    chk(0, "t2_grant1", gq[g0+1], 4'b1000);
    chk(0, "t2_grant2", gq[g0+2], 4'b0100);
    chk(0, "t2_data1", gd[g0+1], 120'h333);
    chk(0, "t2_gap01", pcyc[p0+1] - pcyc[p0], 2);
    chk(0, "t2_gap12", pcyc[p0+2] - pcyc[p0+1], 2);
    chk(0, "t2_frames", fa, 16'd4);
    chk(0, "t2_drops", da, 16'd0);
    chk(1, "t2_frames", fb, 16'd2);
    chk(1, "t2_drops", db, 16'd2);

    // Bad headers: mark, reserved bits, channel beyond NUM_CH=2
    pb = pops[1]; vb = vcyc[1];
    push(8'h51, 120'h5); push(8'hA5, 120'h6); push(8'hA2, 120'h7);
    settle(30);
    chk(1, "t3_drops", db, 16'd5);
    chk(1, "t3_no_valid", vcyc[1] - vb, 0);
    chk(1, "t3_pops", pops[1] - pb, 3);
    chk(0, "t3_drops", da, 16'd2);
    chk(0, "t3_frames", fa, 16'd5);

    // Timeout with READY low; dut_b (timeout disabled) keeps holding
    rdy = 4'h0; v0 = vcyc[0];
    push(8'hA1, 120'hBEEF);
    cycles(12);
    chk(0, "t4_valid_cycles", vcyc[0] - v0, 5);
    chk(0, "t4_drops", da, 16'd3);
    chk(0, "t4_idle", ba, 1'b0);
    chk(1, "t4_hold", bb, 1'b1);
    chk(1, "t4_hold_valid", ib.CH_VALID, 2'b10);
    rdy = 4'hF;
    settle(20);
    chk(1, "t4_frames", fb, 16'd3);

    // READY arrives on the last allowed cycle: transfer wins
    rdy = 4'h0; v0 = vcyc[0];
    push(8'hA1, 120'hCAFE);
    for (int i = 0; i < 20 && (vcyc[0] - v0) < 4; i++) @(negedge clk);
    rdy = 4'hF;
    settle(20);
    chk(0, "t4b_valid_cycles", vcyc[0] - v0, 5);
    chk(0, "t4b_frames", fa, 16'd6);
    chk(0, "t4b_drops", da, 16'd3);
    chk(1, "t4b_frames", fb, 16'd4);

    // EN falls while a frame is held
    rdy = 4'h0; p0 = pops[0];
    push(8'hA1, 120'hA); push(8'hA1, 120'hB); push(8'hA1, 120'hC);
    cycles(2);
    en = 1'b0; rdy = 4'hF;
    cycles(6);
    chk(0, "t5_pops", pops[0] - p0, 1);
    chk(0, "t5_queued", wr - a_rd, 2);
    chk(0, "t5_frames", fa, 16'd7);
    chk(0, "t5_idle", ba, 1'b0);
    en = 1'b1;
    settle(20);
    chk(0, "t5_frames_after", fa, 16'd9);
    chk(1, "t5_frames_after", fb, 16'd7);

    // Reset while a frame is held
    rdy = 4'h0;
    push(8'hA1, 120'hDEAD);
    cycles(2);
    rst = 1'b1;
    cycles(1);
    chk(0, "rst_mid_frames", fa, 16'd0);
    chk(0, "rst_mid_drops", da, 16'd0);
    chk(0, "rst_mid_valid", ia.CH_VALID, 4'h0);
    chk(0, "rst_mid_data", ia.CH_DATA, 120'h0);
    chk(0, "rst_mid_busy", ba, 1'b0);
    chk(1, "rst_mid_frames", fb, 16'd0);
    chk(0, "rst_mid_popped", a_rd, wr);
    rst = 1'b0;

    // Drop counter saturation from a preloaded near-full value
    en = 1'b0;
    cycles(1);
    force dut_a.u_drop_cnt.cnt = 16'hFFFE;
    preload_a = 1'b1;
    cycles(1);
    release dut_a.u_drop_cnt.cnt;
    cycles(1);
    chk(0, "t6_preload", da, 16'hFFFE);
    en = 1'b1;
    push(8'h51, 120'h1); push(8'h51, 120'h2); push(8'h51, 120'h3);
    settle(30);
    chk(0, "t6_sat", da, 16'hFFFF);
    chk(1, "t6_drops", db, 16'd3);

    cycles(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/lpce_rx_dispatch.md
# lpce_rx_dispatch

Read-side controller for the LPCE receive path. It drains 128-bit frames from the receive FIFO's show-ahead read port, checks each frame's header byte, and routes the 120-bit payload to one of `NUM_CH` consumer ports over a valid/ready handshake. Invalid frames and frames that stall too long are dropped and counted. It runs entirely in the FIFO read clock domain, between the FIFO read port and the downstream consumers.

## Interface
- `NUM_CH`, 4: number of consumer channels; allowed values 1..4.
- `TIMEOUT`, 255: maximum number of cycles a frame may wait for READY before it is dropped; 0 disables the timeout.
- `READ_CLK`  in  1  FIFO read clock; the block's only clock.
- `RSTi`  in  1  synchronous, active-high reset.
- `EN`  in  1  dispatch enable; gates new pops only.
- `READ_DATA`  in  128  FIFO head word; show-ahead, valid whenever `READ_EMPT`=0.
- `READ_EMPT`  in  1  FIFO empty.
- `READ_EN`  out  1  FIFO pop strobe; one pop per high cycle.
- `CH_DATA`  out  120  payload; shared by all channels.
- `CH_VALID`  out  NUM_CH  one-hot per-channel valid.
- `CH_READY`  in  NUM_CH  per-channel ready.
- `FRAME_CNT`  out  16  frames delivered; saturating.
- `DROP_CNT`  out  16  frames dropped (bad header or timeout); saturating.
- `BUSY`  out  1  high when the FSM is not in IDLE.

## Operation
- Header = `READ_DATA[127:120]`.
- Header is valid iff `hdr[7:4]`=4'hA and `hdr[3:2]`=2'b00 and `hdr[1:0]` < `NUM_CH`.
- Channel = `hdr[1:0]`. Payload = `READ_DATA[119:0]`.
- FSM states: IDLE, SEND, DROP.
- IDLE: if `EN` & !`READ_EMPT`:
  - assert `READ_EN` combinationally for that cycle;
  - capture payload and channel;
  - decode header from `READ_DATA` in the same cycle;
  - go to SEND if the header is valid, else to DROP.
- SEND:
  - `CH_VALID[ch]`=1; `CH_DATA` is held stable;
  - on `CH_VALID[ch]` & `CH_READY[ch]`: increment `FRAME_CNT`, go to IDLE;
  - on timeout: increment `DROP_CNT`, go to IDLE.
- DROP: increment `DROP_CNT`, go to IDLE. Lasts one cycle.
- Timeout counter:
  - width $clog2(`TIMEOUT`+1); cleared on entry to SEND;
  - increments each SEND cycle in which READY is low;
  - fires when the count equals `TIMEOUT` and READY is still low;
  - READY and timeout in the same cycle: the transfer wins and counts in `FRAME_CNT`.
- `EN` falling during SEND: the current frame completes normally; no further pops.
- `READ_EN` is never asserted outside IDLE, and never while `READ_EMPT`=1.
- Counters hold at 16'hFFFF; they never wrap.
- `CH_READY` of non-addressed channels is ignored.

## Timing
- Reset values:
  - state IDLE;
  - `READ_EN`=0 and `CH_VALID`=0 (combinational from IDLE with `EN` gating);
  - `CH_DATA`=0, `FRAME_CNT`=0, `DROP_CNT`=0, `BUSY`=0, timeout counter 0.
- Pop at cycle t → `CH_VALID` high at t+1.
- Ready already high at t+1 → transfer at t+1, IDLE at t+2, next pop at t+2. Peak rate is 1 frame per 2 cycles.
- Bad header popped at t → DROP at t+1 → `DROP_CNT` updates at t+2 → next pop at t+2.
- Timeout with `TIMEOUT`=N: `CH_VALID` is high for N+1 cycles, then drops; `DROP_CNT` increments on the following edge.
- `RSTi` mid-SEND: the frame is discarded (already popped) and not counted; all outputs return to reset values on the next edge.

## Structure
- Package `lpce_pkg` holds:
  - `LPCE_HDR_MARK`=4'hA and header field positions;
  - the FSM state enum (IDLE/SEND/DROP);
  - the payload width constant 120.
- One sub-module, `lpce_sat_cnt`: a 16-bit saturating counter with synchronous clear and increment. Instantiated twice, for `FRAME_CNT` and `DROP_CNT`.

## Test plan
- Single frame 0xA1, payload 120'h1234, `CH_READY`=4'b1111 → `READ_EN` 1 cycle, `CH_VALID`=4'b0010 for 1 cycle, `CH_DATA`=120'h1234, `FRAME_CNT`=1.
- Three back-to-back frames to channels 0, 3, 2 with ready always high → pops 2 cycles apart, `CH_VALID` sequence 0001, 1000, 0100, `FRAME_CNT`=3, `DROP_CNT`=0.
- Headers 0x51, 0xA5, and 0xA2 with `NUM_CH`=2 → no `CH_VALID` asserted, `DROP_CNT`=3, each FIFO entry popped exactly once.
- `TIMEOUT`=4, channel 1 READY held low → `CH_VALID[1]` high exactly 5 cycles, then `DROP_CNT`=1, FSM back to IDLE; a second run with READY rising on the 5th cycle → `FRAME_CNT`=1, `DROP_CNT` unchanged.
- `EN` falls while in SEND with 2 frames queued → the current frame completes; no `READ_EN` until `EN` returns; `RSTi` during SEND → all outputs at reset values next cycle, counters 0.
- Preload `DROP_CNT` to 16'hFFFE via 65534 bad frames (or a forced state), then send 3 more bad frames → `DROP_CNT` holds at 16'hFFFF.
